// File: rtl/priority_encoder_q.sv
// Registered priority encoder with sticky pending requests and a
// valid/ready grant. Fixed priority or round-robin selection.
module priority_encoder_q #(
  parameter int WIDTH  = 8,
  parameter int CODE_W = 3,
  parameter bit RR     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  data,
  input  logic [WIDTH-1:0]  mask,
  input  logic              ready,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [WIDTH-1:0]  pending,
  output logic              dup
);

  logic              accept;
  logic [WIDTH-1:0]  clr;
  logic [WIDTH-1:0]  kept;
  logic [WIDTH-1:0]  pend_nx;
  logic [WIDTH-1:0]  elig;
  logic [CODE_W-1:0] sel;
  logic [CODE_W-1:0] ptr;
  logic [CODE_W-1:0] idx;

  assign accept  = valid & ready;
  assign clr     = accept ? (WIDTH'(1) << code) : '0;
  assign kept    = pending & ~clr;
  assign pend_nx = kept | data;
  assign elig    = pend_nx & mask;

  // Scan from the far end so the last hit is the highest-priority one.
  always_comb begin
    sel = '0;
    idx = '0;
    if (RR) begin
      for (int k = WIDTH; k >= 1; k--) begin
        idx = ptr + CODE_W'(k);
        if (elig[idx]) sel = idx;
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (elig[i]) sel = CODE_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      code    <= '0;
      valid   <= 1'b0;
      dup     <= 1'b0;
      ptr     <= CODE_W'(WIDTH - 1);
    end else begin
      pending <= pend_nx;
      if (|(data & kept)) dup <= 1'b1;
      if (accept) ptr <= code;
      if (!(valid && !ready)) begin
        valid <= |elig;
        code  <= (|elig) ? sel : '0;
      end
    end
  end

endmodule

// File: tb/tb_priority_encoder_q.sv
// Directed bench: fixed-priority instance and round-robin instance
// share stimulus; each phase checks the relevant instance.
module tb_priority_encoder_q;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic [7:0] mask;
  logic       ready;

  logic [2:0] code0, code1;
  logic       valid0, valid1;
  logic [7:0] pend0, pend1;
  logic       dup0, dup1;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  priority_encoder_q #(.WIDTH(8), .CODE_W(3), .RR(1'b0)) dut0 (
    .clk(clk), .reset(reset), .data(data), .mask(mask),
    .ready(ready), .code(code0), .valid(valid0),
    .pending(pend0), .dup(dup0)
  );

  priority_encoder_q #(.WIDTH(8), .CODE_W(3), .RR(1'b1)) dut1 (
    .clk(clk), .reset(reset), .data(data), .mask(mask),
    .ready(ready), .code(code1), .valid(valid1),
    .pending(pend1), .dup(dup1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    data  = '0;
    ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    mask = 8'hFF;
    do_reset();
    chk("rst_pend", pend0, 8'h00);
    chk("rst_valid", valid0, 1'b0);
    chk("rst_code", code0, 3'd0);
    chk("rst_dup", dup0, 1'b0);
    chk("rst_valid_rr", valid1, 1'b0);

    // fixed priority drain
    data = 8'h94; step();
    chk("fx_c2", code0, 3'd2);
    chk("fx_v2", valid0, 1'b1);
    data = 8'h00; ready = 1'b1; step();
    chk("fx_c4", code0, 3'd4);
    step();
    chk("fx_c7", code0, 3'd7);
    chk("fx_p7", pend0, 8'h80);
    step();
    chk("fx_vend", valid0, 1'b0);
    chk("fx_cend", code0, 3'd0);
    chk("fx_pend", pend0, 8'h00);

    // stall and hold
    ready = 1'b0; data = 8'h08; step();
    chk("st_c3", code0, 3'd3);
    data = 8'h01; step();
    chk("st_hold", code0, 3'd3);
    chk("st_pend", pend0, 8'h09);
    data = 8'h00; step();
    chk("st_hold2", code0, 3'd3);
    chk("st_v", valid0, 1'b1);
    ready = 1'b1; step();
    chk("st_c0", code0, 3'd0);
    step();
    chk("st_vend", valid0, 1'b0);
    ready = 1'b0;

    // mask and dup
    mask = 8'hFE; data = 8'h01; step();
    chk("mk_v", valid0, 1'b0);
    chk("mk_p", pend0, 8'h01);
    chk("mk_dup0", dup0, 1'b0);
    data = 8'h00; mask = 8'hFF; step();
    chk("mk_v1", valid0, 1'b1);
    chk("mk_c0", code0, 3'd0);
    data = 8'h01; step();
    chk("dup_set", dup0, 1'b1);
    ready = 1'b1; step();
    chk("sw_pend", pend0, 8'h01);
    chk("sw_v", valid0, 1'b1);
    chk("sw_c", code0, 3'd0);
    data = 8'h00; step();
    chk("sw_vend", valid0, 1'b0);
    chk("sw_pend0", pend0, 8'h00);
    chk("dup_sticky", dup0, 1'b1);

    // round-robin
    do_reset();
    chk("rr_rst_dup", dup1, 1'b0);
    data = 8'hFF; step();
    chk("rr_c0", code1, 3'd0);
    data = 8'h00; ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("rr_c%0d", i), code1, 32'(i));
    end
    step();
    chk("rr_vend", valid1, 1'b0);
    ready = 1'b0; data = 8'h03; step();
    chk("rr_03a", code1, 3'd0);
    data = 8'h00; ready = 1'b1; step();
    chk("rr_03b", code1, 3'd1);
    step();
    chk("rr_03v", valid1, 1'b0);

    // wrap
    ready = 1'b0; data = 8'h20; step();
    chk("wr_g5", code1, 3'd5);
    data = 8'h00; ready = 1'b1; step();
    chk("wr_v0", valid1, 1'b0);
    ready = 1'b0; data = 8'h21; step();
    chk("wr_c0", code1, 3'd0);
    data = 8'h00; ready = 1'b1; step();
    chk("wr_c5", code1, 3'd5);
    step();
    chk("wr_vend", valid1, 1'b0);

    // pointer at 5: bit 7 beats bit 0
    ready = 1'b0; data = 8'h81; step();
    chk("rr_p7", code1, 3'd7);
    chk("fx_p0", code0, 3'd0);
    data = 8'h00; ready = 1'b1; step();
    chk("rr_p0", code1, 3'd0);
    step();
    chk("rr_pend", pend1, 8'h00);
    chk("rr_pv", valid1, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
